// File: rtl/lift53_pkg.sv
// Shared types and lifting constants for the inverse LeGall 5/3 row engine.
package lift53_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        RD_R,
        RD_S,
        CAP,
        WR,
        DONE
    } state_t;

    typedef enum logic {
        EVEN,
        ODD
    } pass_t;

    localparam int UPD_ROUND  = 2;
    localparam int UPD_SHIFT  = 2;
    localparam int PRED_SHIFT = 1;

endpackage

// File: rtl/lift53_inv_alu.sv
// Combinational inverse 5/3 lifting step: undo-update on EVEN, undo-predict on ODD.
module lift53_inv_alu
    import lift53_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             pass_i,
    input  logic [WIDTH-1:0] l_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] s_i,
    output logic [WIDTH-1:0] x_o
);

    localparam int EXT_W = WIDTH + 2;

    logic signed [EXT_W-1:0] l_ext;
    logic signed [EXT_W-1:0] r_ext;
    logic signed [EXT_W-1:0] s_ext;
    logic signed [EXT_W-1:0] sum;

    // Two guard bits keep L+R+round exact; the result wraps back to WIDTH.
    always_comb begin
        l_ext = {{2{l_i[WIDTH-1]}}, l_i};
        r_ext = {{2{r_i[WIDTH-1]}}, r_i};
        s_ext = {{2{s_i[WIDTH-1]}}, s_i};
        sum   = '0;
        x_o   = '0;
        if (pass_i == ODD) begin
            sum = l_ext + r_ext;
            x_o = WIDTH'(s_ext + (sum >>> PRED_SHIFT));
        end else begin
            sum = l_ext + r_ext + EXT_W'(UPD_ROUND);
            x_o = WIDTH'(s_ext - (sum >>> UPD_SHIFT));
        end
    end

endmodule

// File: rtl/lift53_inv_row.sv
// Inverse LeGall 5/3 lifting of one in-place RAM row: EVEN pass rebuilds even samples,
// ODD pass rebuilds odd samples. Five cycles per sample, all strobes registered.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  RD_L  | issue read of left neighbour (mirrored at i=0)
//  RD_R  | issue read of right neighbour (mirrored at i=N-1)
//  RD_S  | issue read of the sample itself; L data returns
//  CAP   | R data returns
//  WR    | S data returns; write strobe follows on the next cycle
//  DONE  | last write issued, o_done pulses next
module lift53_inv_row
    import lift53_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    output logic              o_Rd_En,
    input  logic              i_Rd_DV,
    input  logic [WIDTH-1:0]  i_Rd_Data,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic              o_Wr_DV,
    output logic [WIDTH-1:0]  o_Wr_Data
);

    localparam logic [ADDR_W-1:0] IDX_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_TWO       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] IDX_PASS_LAST = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] IDX_ROW_LAST  = ADDR_W'(DEPTH - 1);

    state_t state_q, state_d;
    pass_t  pass_q, pass_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_dv_q;
    logic [ADDR_W-1:0] wr_addr_q;
    pass_t             wr_pass_q;

    logic [WIDTH-1:0]  l_q;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  s_q;

    logic [ADDR_W-1:0] addr_l;
    logic [ADDR_W-1:0] addr_r;
    logic [WIDTH-1:0]  alu_x;

    // Symmetric extension substitutes the address; the read itself is always issued.
    always_comb begin
        addr_l = idx_q - IDX_ONE;
        addr_r = idx_q + IDX_ONE;
        if (idx_q == '0) begin
            addr_l = IDX_ONE;
        end
        if (idx_q == IDX_ROW_LAST) begin
            addr_r = IDX_PASS_LAST;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RD_L;
                    pass_d  = EVEN;
                    idx_d   = '0;
                end
            end
            RD_L: state_d = RD_R;
            RD_R: state_d = RD_S;
            RD_S: state_d = CAP;
            CAP:  state_d = WR;
            WR: begin
                if (idx_q >= IDX_PASS_LAST) begin
                    if (pass_q == EVEN) begin
                        state_d = RD_L;
                        pass_d  = ODD;
                        idx_d   = IDX_ONE;
                    end else begin
                        state_d = DONE;
                        pass_d  = EVEN;
                        idx_d   = '0;
                    end
                end else begin
                    state_d = RD_L;
                    idx_d   = idx_q + IDX_TWO;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pass_q    <= EVEN;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_dv_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_pass_q <= EVEN;
            l_q       <= '0;
            r_q       <= '0;
            s_q       <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;

            // Strobes trail the state by one cycle, so busy rises the cycle after acceptance.
            busy_q  <= (state_q != IDLE) && (state_q != DONE);
            done_q  <= (state_q == DONE);
            rd_en_q <= (state_q == RD_L) || (state_q == RD_R) || (state_q == RD_S);
            wr_dv_q <= (state_q == WR);

            case (state_q)
                RD_L:    rd_addr_q <= addr_l;
                RD_R:    rd_addr_q <= addr_r;
                RD_S:    rd_addr_q <= idx_q;
                default: rd_addr_q <= rd_addr_q;
            endcase

            // Pass can flip on this same edge, so the ALU uses a copy taken with the write.
            if (state_q == WR) begin
                wr_addr_q <= idx_q;
                wr_pass_q <= pass_q;
            end

            if (i_Rd_DV) begin
                case (state_q)
                    RD_S:    l_q <= i_Rd_Data;
                    CAP:     r_q <= i_Rd_Data;
                    WR:      s_q <= i_Rd_Data;
                    default: ;
                endcase
            end
        end
    end

    lift53_inv_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .pass_i (wr_pass_q),
        .l_i    (l_q),
        .r_i    (r_q),
        .s_i    (s_q),
        .x_o    (alu_x)
    );

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_Rd_En   = rd_en_q;
    assign o_Rd_Addr = rd_addr_q;
    assign o_Wr_DV   = wr_dv_q;
    assign o_Wr_Addr = wr_addr_q;
    assign o_Wr_Data = wr_dv_q ? alu_x : '0;

endmodule

// File: tb/tb_lift53_inv_row.sv
// Bench for lift53_inv_row with a behavioural 1-cycle-latency two-port RAM and a write scoreboard.
module tb_lift53_inv_row;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int ROW_CYCLES = 5 * DEPTH + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              rd_dv;
    logic [WIDTH-1:0]  rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_dv;
    logic [WIDTH-1:0]  wr_data;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  init_row [DEPTH];
    logic [WIDTH-1:0]  orig [DEPTH];
    logic              load_req;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  errors   = 0;
    int  n_writes = 0;

    always #5 clk = ~clk;

    lift53_inv_row #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_Rd_Addr (rd_addr),
        .o_Rd_En   (rd_en),
        .i_Rd_DV   (rd_dv),
        .i_Rd_Data (rd_data),
        .o_Wr_Addr (wr_addr),
        .o_Wr_DV   (wr_dv),
        .o_Wr_Data (wr_data)
    );

    // RAM_2Port stand-in: registered read with DV, write on strobe, bulk load from the bench.
    always @(posedge clk) begin
        rd_dv <= rd_en;
        if (rd_en) rd_data <= mem[rd_addr];
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_row[i];
        end else if (wr_dv) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (wr_dv) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL wr_data got addr=%0d data=%h exp addr=%0d data=%h",
                             wr_addr, wr_data, mon_e.a, mon_e.d);
                end
            end
            checks++;
            if (rd_en && rd_addr == wr_addr) begin
                errors++;
                $display("FAIL rw_same_addr got addr=%0d on both ports, exp distinct", wr_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int sx(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic clear_row();
        for (int i = 0; i < DEPTH; i++) init_row[i] = '0;
    endtask

    task automatic load_row();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Reference inverse on the coefficient row: even samples first, then odd.
    task automatic push_inverse();
        logic [WIDTH-1:0] x [DEPTH];
        int l, r;
        for (int i = 0; i < DEPTH; i += 2) begin
            l = sx(init_row[(i == 0) ? 1 : i - 1]);
            r = sx(init_row[i + 1]);
            x[i] = WIDTH'(sx(init_row[i]) - ((l + r + 2) >>> 2));
            exp_q.push_back({ADDR_W'(i), x[i]});
        end
        for (int i = 1; i < DEPTH; i += 2) begin
            l = sx(x[i - 1]);
            r = sx(x[(i == DEPTH - 1) ? DEPTH - 2 : i + 1]);
            x[i] = WIDTH'(sx(init_row[i]) + ((l + r) >>> 1));
            exp_q.push_back({ADDR_W'(i), x[i]});
        end
    endtask

    // Forward 5/3 of orig into init_row; the inverse must return orig exactly.
    task automatic forward_from_orig();
        int l, r;
        for (int i = 1; i < DEPTH; i += 2) begin
            l = sx(orig[i - 1]);
            r = sx(orig[(i == DEPTH - 1) ? DEPTH - 2 : i + 1]);
            init_row[i] = WIDTH'(sx(orig[i]) - ((l + r) >>> 1));
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            l = sx(init_row[(i == 0) ? 1 : i - 1]);
            r = sx(init_row[i + 1]);
            init_row[i] = WIDTH'(sx(orig[i]) + ((l + r + 2) >>> 2));
        end
        for (int i = 0; i < DEPTH; i += 2) exp_q.push_back({ADDR_W'(i), orig[i]});
        for (int i = 1; i < DEPTH; i += 2) exp_q.push_back({ADDR_W'(i), orig[i]});
    endtask

    // Start a row (accepted at the next edge) and wait for o_done within a cycle budget.
    task automatic run_row(input string tag, input int extra_pulse_at);
        int cyc;
        int w0;
        w0 = n_writes;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check({tag, "_busy_at_accept"}, o_busy, 0);
        cyc = 0;
        while (cyc < 2 * ROW_CYCLES) begin
            i_start = (cyc == extra_pulse_at);
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check({tag, "_busy_after_accept"}, o_busy, 1);
            if (o_done) break;
        end
        i_start = 1'b0;
        check({tag, "_done_seen"}, o_done, 1);
        check({tag, "_done_cycles"}, cyc, ROW_CYCLES);
        check({tag, "_busy_at_done"}, o_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_write_count"}, n_writes - w0, 2 * (DEPTH / 2) * 2 / 2 * 2 / 2);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        i_start  = 1'b0;
        load_req = 1'b0;
        clear_row();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    o_busy, 0);
        check("rst_done",    o_done, 0);
        check("rst_rd_en",   rd_en, 0);
        check("rst_wr_dv",   wr_dv, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: flat row reconstructs to a constant
        for (int i = 0; i < DEPTH; i++) init_row[i] = (i % 2 == 0) ? 16'd216 : 16'd0;
        load_row();
        push_inverse();
        run_row("flat", -1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'd216) bad++;
        check("flat_bad_words", bad, 0);

        // 2: undo-update arithmetic
        clear_row();
        init_row[1] = 16'd215;
        init_row[2] = 16'd216;
        init_row[3] = 16'd217;
        load_row();
        push_inverse();
        run_row("upd", -1);
        check("upd_x2", mem[2], 16'd108);

        // 3: floor on negatives, both passes
        clear_row();
        init_row[3]  = 16'hFFFD;
        init_row[4]  = 16'd10;
        init_row[5]  = 16'hFFFE;
        init_row[9]  = 16'd5;
        init_row[10] = 16'd1;
        load_row();
        push_inverse();
        run_row("neg", -1);
        check("neg_x4",  mem[4],  16'd11);
        check("neg_x8",  mem[8],  16'hFFFF);
        check("neg_x10", mem[10], 16'd0);
        check("neg_x9",  mem[9],  16'd4);

        // 4: mirrored neighbours at both row ends
        clear_row();
        init_row[1]  = 16'd8;
        init_row[60] = 16'd2;
        init_row[62] = 16'd10;
        load_row();
        push_inverse();
        run_row("edge", -1);
        check("edge_x0",  mem[0],  16'hFFFC);
        check("edge_x61", mem[61], 16'd6);
        check("edge_x62", mem[62], 16'd10);
        check("edge_x63", mem[63], 16'd10);

        // 5a: start while busy is ignored
        for (int i = 0; i < DEPTH; i++) init_row[i] = (i % 2 == 0) ? 16'd216 : 16'd0;
        load_row();
        push_inverse();
        run_row("ign", 50);

        // 5b: reset mid-row aborts, then a fresh row completes
        load_row();
        push_inverse();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_busy",  o_busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_dv", wr_dv, 0);
        check("abort_done",  o_done, 0);
        @(posedge clk);
        #1;
        load_row();
        push_inverse();
        run_row("after_rst", -1);

        // 6: random row through forward reference, then back
        for (int i = 0; i < DEPTH; i++) orig[i] = WIDTH'($urandom_range(0, 65535));
        orig[0]  = 16'h7FFF;
        orig[1]  = 16'h8000;
        orig[62] = 16'h8000;
        orig[63] = 16'h7FFF;
        forward_from_orig();
        load_row();
        run_row("trip", -1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== orig[i]) bad++;
        check("trip_bad_words", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
